mem_port_arbiter: RTL and testbench

//  Shares one external memory port between the instruction-fetch requester (I-side) and the

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the I-side (fetch) and D-side (load/store) requesters.
// D wins ties unless I has been starved for STARVE_LIMIT consecutive D grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [31:0] I_ADDR,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic [3:0]  D_READ,
  input  logic [2:0]  D_WRITE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WRITEDATA,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic [3:0]  M_READ,
  output logic [2:0]  M_WRITE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WRITEDATA,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT
);

  // state  | meaning
  // IDLE   | decision cycle, no memory op in flight
  // I_ACC  | I-side word read presented to memory
  // D_ACC  | D-side load/store presented to memory
  // I_DONE | I-side result valid, I_BUSYWAIT released
  // D_DONE | D-side result valid, D_BUSYWAIT released
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ACC  = 3'd1,
    D_ACC  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(STARVE_LIMIT);
  localparam logic [3:0]       I_RD_CTL = 4'b1010;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [3:0]       m_read_q, m_read_d;
  logic [2:0]       m_write_q, m_write_d;
  logic [31:0]      m_addr_q, m_addr_d;
  logic [31:0]      m_wdata_q, m_wdata_d;
  logic [31:0]      i_rdata_q, i_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;

  logic i_req;
  logic d_req;
  logic i_forced;

  assign i_req    = I_READ;
  assign d_req    = D_READ[3] | D_WRITE[2];
  assign i_forced = i_req && (starve_cnt_q == LIMIT_C);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      first_q      <= 1'b0;
      starve_cnt_q <= '0;
      m_read_q     <= '0;
      m_write_q    <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      starve_cnt_q <= starve_cnt_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    starve_cnt_d = starve_cnt_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d   = D_ACC;
          first_d   = 1'b1;
          m_read_d  = D_READ;
          m_write_d = D_WRITE;
          m_addr_d  = D_ADDR;
          m_wdata_d = D_WRITEDATA;
          if (!i_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (i_req) begin
          state_d      = I_ACC;
          first_d      = 1'b1;
          m_read_d     = I_RD_CTL;
          m_write_d    = '0;
          m_addr_d     = I_ADDR;
          starve_cnt_d = '0;
        end
      end

      // The memory registers its busywait, so it is only meaningful from the second cycle.
      I_ACC, D_ACC: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!M_BUSYWAIT) begin
          if (state_q == I_ACC) begin
            i_rdata_d = M_READDATA;
            state_d   = I_DONE;
          end else begin
            if (m_read_q[3]) begin
              d_rdata_d = M_READDATA;
            end
            state_d = D_DONE;
          end
          m_read_d  = '0;
          m_write_d = '0;
        end
      end

      I_DONE, D_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign I_BUSYWAIT  = i_req && (state_q != I_DONE);
  assign D_BUSYWAIT  = d_req && (state_q != D_DONE);
  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;
  assign M_READ      = m_read_q;
  assign M_WRITE     = m_write_q;
  assign M_ADDR      = m_addr_q;
  assign M_WRITEDATA = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory,
// with hand-computed expectations checked by immediate assertions.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDR;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic [3:0]  D_READ;
  logic [2:0]  D_WRITE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic [3:0]  M_READ;
  logic [2:0]  M_WRITE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WRITEDATA;
  logic [31:0] M_READDATA;
  logic        M_BUSYWAIT;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .I_READ      (I_READ),
    .I_ADDR      (I_ADDR),
    .I_READDATA  (I_READDATA),
    .I_BUSYWAIT  (I_BUSYWAIT),
    .D_READ      (D_READ),
    .D_WRITE     (D_WRITE),
    .D_ADDR      (D_ADDR),
    .D_WRITEDATA (D_WRITEDATA),
    .D_READDATA  (D_READDATA),
    .D_BUSYWAIT  (D_BUSYWAIT),
    .M_READ      (M_READ),
    .M_WRITE     (M_WRITE),
    .M_ADDR      (M_ADDR),
    .M_WRITEDATA (M_WRITEDATA),
    .M_READDATA  (M_READDATA),
    .M_BUSYWAIT  (M_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] starve_addr [6];

  initial begin
    RESET       = 1'b1;
    I_READ      = 1'b0;
    I_ADDR      = '0;
    D_READ      = '0;
    D_WRITE     = '0;
    D_ADDR      = '0;
    D_WRITEDATA = '0;
    M_READDATA  = '0;
    M_BUSYWAIT  = 1'b0;

    // reset state
    step();
    step();
    chk("rst_m_read",   32'(M_READ), 32'h0);
    chk("rst_m_write",  32'(M_WRITE), 32'h0);
    chk("rst_m_addr",   M_ADDR, 32'h0);
    chk("rst_m_wdata",  M_WRITEDATA, 32'h0);
    chk("rst_i_rdata",  I_READDATA, 32'h0);
    chk("rst_d_rdata",  D_READDATA, 32'h0);
    chk("rst_i_busy",   32'(I_BUSYWAIT), 32'h0);
    chk("rst_d_busy",   32'(D_BUSYWAIT), 32'h0);
    RESET = 1'b0;

    // 1: single zero-wait I read; edge0 grant, edge1 busywait ignored, edge2 completes
    I_READ = 1'b1; I_ADDR = 32'h40; M_READDATA = 32'hDEADBEEF;
    #1 chk("t1_ibusy_idle", 32'(I_BUSYWAIT), 32'h1);
    step();
    chk("t1_m_read",  32'(M_READ), 32'hA);
    chk("t1_m_addr",  M_ADDR, 32'h40);
    chk("t1_ibusy_a1", 32'(I_BUSYWAIT), 32'h1);
    step();
    chk("t1_ibusy_a2", 32'(I_BUSYWAIT), 32'h1);
    step();
    chk("t1_ibusy_done", 32'(I_BUSYWAIT), 32'h0);
    chk("t1_i_rdata", I_READDATA, 32'hDEADBEEF);
    chk("t1_m_read_clr", 32'(M_READ), 32'h0);
    chk("t1_dbusy", 32'(D_BUSYWAIT), 32'h0);
    I_READ = 1'b0;
    step();

    // 2: simultaneous I read and D store; D first, then I
    I_READ = 1'b1; I_ADDR = 32'h44;
    D_WRITE = 3'b110; D_ADDR = 32'h100; D_WRITEDATA = 32'h12345678;
    M_READDATA = 32'hCAFEF00D;
    step();
    chk("t2_m_write", 32'(M_WRITE), 32'h6);
    chk("t2_m_addr",  M_ADDR, 32'h100);
    chk("t2_m_wdata", M_WRITEDATA, 32'h12345678);
    chk("t2_m_read",  32'(M_READ), 32'h0);
    chk("t2_ibusy_d", 32'(I_BUSYWAIT), 32'h1);
    step();
    step();
    chk("t2_dbusy_done", 32'(D_BUSYWAIT), 32'h0);
    chk("t2_ibusy_ddone", 32'(I_BUSYWAIT), 32'h1);
    chk("t2_d_rdata_keep", D_READDATA, 32'h0);
    D_WRITE = 3'b000;
    step();
    chk("t2_ibusy_idle", 32'(I_BUSYWAIT), 32'h1);
    step();
    chk("t2_i_m_read", 32'(M_READ), 32'hA);
    chk("t2_i_m_addr", M_ADDR, 32'h44);
    step();
    step();
    chk("t2_ibusy_done", 32'(I_BUSYWAIT), 32'h0);
    chk("t2_i_rdata", I_READDATA, 32'hCAFEF00D);
    I_READ = 1'b0;
    step();

    // 3: D read with memory busy for three access cycles -> busy 5 cycles, low on 6th
    D_READ = 4'b1010; D_ADDR = 32'h200; M_READDATA = 32'h55AA1234; M_BUSYWAIT = 1'b1;
    #1 chk("t3_dbusy_c1", 32'(D_BUSYWAIT), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t3_dbusy_c%0d", k + 2), 32'(D_BUSYWAIT), 32'h1);
      chk($sformatf("t3_m_addr_c%0d", k + 2), M_ADDR, 32'h200);
      chk($sformatf("t3_m_read_c%0d", k + 2), 32'(M_READ), 32'hA);
      if (k == 3) M_BUSYWAIT = 1'b0;
    end
    step();
    chk("t3_dbusy_c6", 32'(D_BUSYWAIT), 32'h0);
    chk("t3_d_rdata", D_READDATA, 32'h55AA1234);
    D_READ = 4'b0000;
    step();

    // 4: starvation bound; four D grants, then I, then D resumes
    starve_addr[0] = 32'h300; starve_addr[1] = 32'h300; starve_addr[2] = 32'h300;
    starve_addr[3] = 32'h300; starve_addr[4] = 32'h80;  starve_addr[5] = 32'h300;
    D_READ = 4'b1010; D_ADDR = 32'h300; I_READ = 1'b1; I_ADDR = 32'h80;
    M_READDATA = 32'h77770000;
    for (int g = 0; g < 6; g++) begin
      step();
      chk($sformatf("t4_grant%0d_addr", g + 1), M_ADDR, starve_addr[g]);
      step();
      step();
      if (g == 4) chk("t4_i_rdata", I_READDATA, 32'h77770000);
      if (g == 5) begin
        D_READ = 4'b0000;
        I_READ = 1'b0;
      end
      step();
    end

    // 5: reset during a stalled D access
    chk("t5_d_rdata_pre", D_READDATA, 32'h77770000);
    D_READ = 4'b1100; D_ADDR = 32'h400; M_BUSYWAIT = 1'b1;
    step();
    chk("t5_m_read_acc", 32'(M_READ), 32'hC);
    step();
    RESET = 1'b1;
    step();
    chk("t5_m_read_rst",  32'(M_READ), 32'h0);
    chk("t5_m_write_rst", 32'(M_WRITE), 32'h0);
    chk("t5_m_addr_rst",  M_ADDR, 32'h0);
    chk("t5_d_rdata_rst", D_READDATA, 32'h0);
    chk("t5_i_rdata_rst", I_READDATA, 32'h0);
    RESET = 1'b0; D_READ = 4'b0000; M_BUSYWAIT = 1'b0;
    I_READ = 1'b1; I_ADDR = 32'h90; M_READDATA = 32'h13572468;
    step();
    chk("t5_i_m_read", 32'(M_READ), 32'hA);
    chk("t5_i_m_addr", M_ADDR, 32'h90);
    step();
    step();
    chk("t5_ibusy_done", 32'(I_BUSYWAIT), 32'h0);
    chk("t5_i_rdata", I_READDATA, 32'h13572468);
    I_READ = 1'b0;
    step();

    // 6: D read request withdrawn mid-access still completes
    D_READ = 4'b1010; D_ADDR = 32'h500; M_READDATA = 32'h2468ACE0;
    step();
    chk("t6_m_addr", M_ADDR, 32'h500);
    D_READ = 4'b0000;
    #1 chk("t6_dbusy_drop", 32'(D_BUSYWAIT), 32'h0);
    step();
    chk("t6_m_read_hold", 32'(M_READ), 32'hA);
    step();
    chk("t6_d_rdata", D_READDATA, 32'h2468ACE0);
    chk("t6_m_read_clr", 32'(M_READ), 32'h0);
    step();
    I_READ = 1'b1; I_ADDR = 32'hA0;
    step();
    chk("t6_idle_regrant_addr", M_ADDR, 32'hA0);
    chk("t6_idle_regrant_read", 32'(M_READ), 32'hA);
    I_READ = 1'b0;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
